pmem_scheduler: RTL and testbench

PMEM_SCHEDULER -- requirements
Module: pmem_scheduler

---
 rtl/pmem_scheduler.sv | 147 ++++++++++++++
 tb/tb_pmem_scheduler.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pmem_scheduler.sv
// pmem_scheduler: arbitrates I-cache and D-cache line requests onto a single
// physical-memory port. D wins ties, but only for D_STREAK_MAX consecutive
// grants while I waits; then I is served. One transaction is in flight at a
// time: IDLE -> BUSY_x -> DONE -> IDLE.
module pmem_scheduler #(
  parameter int D_STREAK_MAX = 4,
  parameter int LINE_W       = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  // I-cache side
  input  logic              i_read,
  input  logic              i_write,
  input  logic [31:0]       i_addr,
  input  logic [LINE_W-1:0] i_wdata,
  output logic              i_resp,
  output logic [LINE_W-1:0] i_rdata,
  // D-cache side
  input  logic              d_read,
  input  logic              d_write,
  input  logic [31:0]       d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              d_resp,
  output logic [LINE_W-1:0] d_rdata,
  // Physical memory side
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [31:0]       pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic              pmem_resp,
  input  logic [LINE_W-1:0] pmem_rdata
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY_I = 2'd1;
  localparam logic [1:0] BUSY_D = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  // Streak counter must be able to hold D_STREAK_MAX itself.
  localparam int STREAK_W = (D_STREAK_MAX < 1) ? 1 : $clog2(D_STREAK_MAX + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(D_STREAK_MAX);

  logic [1:0]          state;
  logic [1:0]          state_nxt;
  logic [STREAK_W-1:0] d_streak;
  logic                served_d;   // transaction in flight belongs to D
  logic                lat_write;
  logic [31:0]         lat_addr;
  logic [LINE_W-1:0]   lat_wdata;
  logic [LINE_W-1:0]   line_q;     // shared read-line register

  logic i_pend;
  logic d_pend;
  logic grant_i;
  logic grant_d;
  logic busy;

  assign i_pend = i_read | i_write;
  assign d_pend = d_read | d_write;
  assign busy   = (state == BUSY_I) || (state == BUSY_D);

  // Arbitration, only in IDLE: D wins ties until its streak allowance is spent.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    grant_d = 1'b0;
    grant_i = 1'b0;
    if (state == IDLE) begin
      grant_d = d_pend && !(i_pend && (d_streak == STREAK_MAX));
      grant_i = i_pend && !grant_d;
    end
  end

  // Next-state logic for the single-transaction sequencer.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_d)      state_nxt = BUSY_D;
        else if (grant_i) state_nxt = BUSY_I;
      end
      BUSY_I,
      BUSY_D: if (pmem_resp) state_nxt = DONE;
      DONE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments so every register samples pre-edge
    // values, independent of block ordering.
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // D streak: counts D grants that overtook a waiting I, saturating at max.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_streak <= '0;
    end else if (grant_i) begin
      d_streak <= '0;
    end else if (grant_d) begin
      if (!i_pend)                     d_streak <= '0;
      else if (d_streak != STREAK_MAX) d_streak <= d_streak + STREAK_W'(1);
    end
  end

  // Capture the granted command so later requester changes cannot disturb it.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: these wide registers are reset because they drive outputs that
    // must read zero while reset is held.
    if (!rst_n) begin
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_write <= 1'b0;
      served_d  <= 1'b0;
    end else if (grant_d) begin
      lat_addr  <= d_addr;
      lat_wdata <= d_wdata;
      lat_write <= d_write;   // read+write together resolves to a write
      served_d  <= 1'b1;
    end else if (grant_i) begin
      lat_addr  <= i_addr;
      lat_wdata <= i_wdata;
      lat_write <= i_write;
      served_d  <= 1'b0;
    end
  end

  // Capture returned line on completion; responses outside BUSY are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                line_q <= '0;
    else if (busy && pmem_resp) line_q <= pmem_rdata;
  end

  assign pmem_read    = busy & ~lat_write;
  assign pmem_write   = busy &  lat_write;
  assign pmem_address = lat_addr;
  assign pmem_wdata   = lat_wdata;

  assign i_resp  = (state == DONE) & ~served_d;
  assign d_resp  = (state == DONE) &  served_d;
  assign i_rdata = line_q;
  assign d_rdata = line_q;

endmodule

// File: tb/tb_pmem_scheduler.sv
// Testbench for pmem_scheduler: a memory responder checks each memory
// command against a queue of expected transactions, and a response monitor
// checks each i_resp/d_resp against per-port queues of expected lines.
module tb_pmem_scheduler;

  localparam int LW  = 256;
  localparam int DSM = 4;

  typedef logic [LW-1:0] line_t;
  typedef struct {
    logic [31:0] addr;
    logic        wr;
    line_t       wdata;
  } txn_t;
  typedef struct {
    logic  chk;    // compare rdata (reads only)
    line_t data;
  } resp_t;

  logic        clk;
  logic        rst_n;
  logic        i_read, i_write, d_read, d_write;
  logic [31:0] i_addr, d_addr;
  line_t       i_wdata, d_wdata, i_rdata, d_rdata;
  logic        i_resp, d_resp;
  logic        pmem_read, pmem_write, pmem_resp;
  logic [31:0] pmem_address;
  line_t       pmem_wdata, pmem_rdata;

  int    n_cmp = 0;
  int    n_bad = 0;
  int    cyc = 0;
  int    mem_lat = 2;     // cycles from first strobe cycle to pmem_resp cycle
  int    strobe_cyc = -1; // cycle of most recent new memory command
  bit    spur_req = 0;    // ask responder for one stray pmem_resp in IDLE
  line_t mem [logic [31:0]];

  txn_t  exp_txn [$];
  resp_t exp_i [$];
  resp_t exp_d [$];

  pmem_scheduler #(.D_STREAK_MAX(DSM), .LINE_W(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_read(i_read), .i_write(i_write), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_resp(i_resp), .i_rdata(i_rdata),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_resp(d_resp), .d_rdata(d_rdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  function automatic line_t mem_val(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {8{a ^ 32'h5A5A_0000}};
  endfunction

  // Memory model: checks each new command, holds it for mem_lat cycles, responds.
  initial begin : responder
    txn_t        e;
    line_t       rd;
    logic        abort;
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst_n && (pmem_read || pmem_write)) begin
        strobe_cyc = cyc;
        n_cmp++;
        if (exp_txn.size() == 0) begin
          n_bad++;
          $display("FAIL txn_unexpected: got addr %h rd %b wr %b, required no command",
                   pmem_address, pmem_read, pmem_write);
          e.addr = pmem_address; e.wr = pmem_write; e.wdata = pmem_wdata;
        end else begin
          e = exp_txn.pop_front();
          if (pmem_address !== e.addr || pmem_write !== e.wr || pmem_read !== !e.wr) begin
            n_bad++;
            $display("FAIL txn_cmd: got addr %h rd %b wr %b, required addr %h rd %b wr %b",
                     pmem_address, pmem_read, pmem_write, e.addr, !e.wr, e.wr);
          end
          if (e.wr) begin
            n_cmp++;
            if (pmem_wdata !== e.wdata) begin
              n_bad++;
              $display("FAIL txn_wdata: got %h, required %h", pmem_wdata, e.wdata);
            end
          end
        end
        if (pmem_write) mem[pmem_address] = pmem_wdata;
        rd = pmem_write ? {8{~pmem_address}} : mem_val(pmem_address);
        abort = 1'b0;
        for (int i = 1; i <= mem_lat; i++) begin
          @(posedge clk); #1;
          if (!rst_n) begin abort = 1'b1; break; end
          if (i < mem_lat) begin
            @(negedge clk);
            if (!rst_n) begin abort = 1'b1; break; end
            n_cmp++;
            if (pmem_address !== e.addr || pmem_write !== e.wr || pmem_read !== !e.wr) begin
              n_bad++;
              $display("FAIL txn_hold: got addr %h rd %b wr %b, required addr %h rd %b wr %b",
                       pmem_address, pmem_read, pmem_write, e.addr, !e.wr, e.wr);
            end
          end
        end
        if (!abort) begin
          pmem_resp = 1'b1; pmem_rdata = rd;
          @(posedge clk); #1;
          pmem_resp = 1'b0; pmem_rdata = '0;
        end
      end else if (spur_req) begin
        @(posedge clk); #1;
        pmem_resp = 1'b1; pmem_rdata = {8{32'hDEAD_BEEF}};
        @(posedge clk); #1;
        pmem_resp = 1'b0; pmem_rdata = '0;
        spur_req = 1'b0;
      end
    end
  end

  // Response monitor: each x_resp cycle consumes one expected response.
  initial begin : resp_mon
    resp_t e;
    forever begin
      @(negedge clk);
      if (i_resp === 1'b1 && d_resp === 1'b1) begin
        n_cmp++; n_bad++;
        $display("FAIL both_resp: got i_resp=1 d_resp=1 at cycle %0d, required at most one", cyc);
      end
      if (i_resp === 1'b1) begin
        n_cmp++;
        if (exp_i.size() == 0) begin
          n_bad++;
          $display("FAIL i_resp_unexpected: got i_resp=1 at cycle %0d, required 0", cyc);
        end else begin
          e = exp_i.pop_front();
          if (e.chk && i_rdata !== e.data) begin
            n_bad++;
            $display("FAIL i_rdata: got %h, required %h", i_rdata, e.data);
          end
        end
      end
      if (d_resp === 1'b1) begin
        n_cmp++;
        if (exp_d.size() == 0) begin
          n_bad++;
          $display("FAIL d_resp_unexpected: got d_resp=1 at cycle %0d, required 0", cyc);
        end else begin
          e = exp_d.pop_front();
          if (e.chk && d_rdata !== e.data) begin
            n_bad++;
            $display("FAIL d_rdata: got %h, required %h", d_rdata, e.data);
          end
        end
      end
    end
  end

  // Raise a request, hold it until its response (bounded), then drop it.
  task automatic drive_req(input bit is_d, input logic [31:0] a, input logic rd,
                           input logic wr, input line_t wd, input int budget,
                           output int resp_at);
    if (is_d) begin d_addr = a; d_read = rd; d_write = wr; d_wdata = wd; end
    else      begin i_addr = a; i_read = rd; i_write = wr; i_wdata = wd; end
    resp_at = -1;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if ((is_d ? d_resp : i_resp) === 1'b1) begin resp_at = cyc; break; end
    end
    n_cmp++;
    if (resp_at < 0) begin
      n_bad++;
      $display("FAIL %s_timeout: got no response in %0d cycles, required one",
               is_d ? "d" : "i", budget);
    end
    @(posedge clk); #1;
    if (is_d) begin d_read = 1'b0; d_write = 1'b0; end
    else      begin i_read = 1'b0; i_write = 1'b0; end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    i_read = 0; i_write = 0; i_addr = '0; i_wdata = '0;
    d_read = 0; d_write = 0; d_addr = '0; d_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({pmem_read, pmem_write, i_resp, d_resp} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_strobes: got rd/wr/iresp/dresp %b, required 0000",
               {pmem_read, pmem_write, i_resp, d_resp});
    end
    n_cmp++;
    if (pmem_address !== 32'h0) begin
      n_bad++; $display("FAIL reset_addr: got %h, required 0", pmem_address);
    end
    n_cmp++;
    if (pmem_wdata !== '0 || i_rdata !== '0 || d_rdata !== '0) begin
      n_bad++;
      $display("FAIL reset_lines: got wdata %h i_rdata %h d_rdata %h, required zeros",
               pmem_wdata, i_rdata, d_rdata);
    end
    @(posedge clk); #2;
    rst_n = 1'b1;
  endtask

  task automatic test_single_read();
    int t, r;
    line_t a5;
    a5 = {32{8'hA5}};
    mem[32'h60] = a5;
    @(posedge clk); #1;
    t = cyc;
    exp_txn.push_back('{32'h60, 1'b0, '0});
    exp_i.push_back('{1'b1, a5});
    drive_req(1'b0, 32'h60, 1'b1, 1'b0, '0, 20, r);
    n_cmp++;
    if (strobe_cyc != t + 1) begin
      n_bad++; $display("FAIL i_strobe_latency: got cycle %0d, required %0d", strobe_cyc, t + 1);
    end
    n_cmp++;
    if (r != t + 4) begin
      n_bad++; $display("FAIL i_resp_latency: got cycle %0d, required %0d", r, t + 4);
    end
    @(negedge clk);
    n_cmp++;
    if (i_resp !== 1'b0 || d_resp !== 1'b0) begin
      n_bad++; $display("FAIL resp_pulse: got i %b d %b after DONE, required 0 0", i_resp, d_resp);
    end
  endtask

  task automatic test_idle_resp();
    spur_req = 1'b1;
    repeat (4) @(negedge clk);
    n_cmp++;
    if (i_rdata !== {32{8'hA5}} || d_rdata !== {32{8'hA5}}) begin
      n_bad++;
      $display("FAIL idle_resp_ignored: got i_rdata %h d_rdata %h, required all A5", i_rdata, d_rdata);
    end
  endtask

  task automatic test_simultaneous();
    int rd_at, ri_at, i_strobe;
    line_t wd;
    wd = {8{32'hC0DE_0200}};
    @(posedge clk); #1;
    exp_txn.push_back('{32'h200, 1'b1, wd});
    exp_txn.push_back('{32'h100, 1'b0, '0});
    exp_d.push_back('{1'b0, '0});
    exp_i.push_back('{1'b1, mem_val(32'h100)});
    fork
      drive_req(1'b1, 32'h200, 1'b0, 1'b1, wd, 30, rd_at);
      begin
        drive_req(1'b0, 32'h100, 1'b1, 1'b0, '0, 30, ri_at);
        i_strobe = strobe_cyc;
      end
    join
    n_cmp++;
    if (i_strobe != rd_at + 2 || ri_at != rd_at + 5) begin
      n_bad++;
      $display("FAIL sim_i_after_d: got i strobe %0d resp %0d, required %0d %0d",
               i_strobe, ri_at, rd_at + 2, rd_at + 5);
    end
  endtask

  task automatic test_streak();
    int r;
    @(posedge clk); #1;
    for (int n = 0; n < 4; n++) exp_txn.push_back('{32'h1000 + 32'(n * 64), 1'b0, '0});
    exp_txn.push_back('{32'h500, 1'b0, '0});
    for (int n = 4; n < 8; n++) exp_txn.push_back('{32'h1000 + 32'(n * 64), 1'b0, '0});
    exp_txn.push_back('{32'h540, 1'b0, '0});
    exp_txn.push_back('{32'h1000 + 32'(8 * 64), 1'b0, '0});
    for (int n = 0; n < 9; n++) exp_d.push_back('{1'b1, mem_val(32'h1000 + 32'(n * 64))});
    exp_i.push_back('{1'b1, mem_val(32'h500)});
    exp_i.push_back('{1'b1, mem_val(32'h540)});
    fork
      begin
        int rd;
        for (int n = 0; n < 9; n++)
          drive_req(1'b1, 32'h1000 + 32'(n * 64), 1'b1, 1'b0, '0, 80, rd);
      end
      begin
        int ri;
        drive_req(1'b0, 32'h500, 1'b1, 1'b0, '0, 100, ri);
        drive_req(1'b0, 32'h540, 1'b1, 1'b0, '0, 100, ri);
      end
    join
    r = exp_txn.size();
    n_cmp++;
    if (r != 0) begin
      n_bad++; $display("FAIL streak_order: got %0d commands outstanding, required 0", r);
    end
  endtask

  task automatic test_addr_hold();
    int r;
    mem_lat = 4;
    @(posedge clk); #1;
    exp_txn.push_back('{32'h300, 1'b0, '0});
    exp_d.push_back('{1'b1, mem_val(32'h300)});
    fork
      drive_req(1'b1, 32'h300, 1'b1, 1'b0, '0, 30, r);
      begin
        repeat (2) @(posedge clk); #2;
        d_addr = 32'h400; d_wdata = {8{32'h1234_5678}};
        @(negedge clk);
        n_cmp++;
        if (pmem_address !== 32'h300) begin
          n_bad++; $display("FAIL addr_hold: got %h, required 00000300", pmem_address);
        end
      end
    join
    mem_lat = 2;
  endtask

  task automatic test_reset_mid();
    int r;
    mem_lat = 6;
    @(posedge clk); #1;
    exp_txn.push_back('{32'h700, 1'b0, '0});
    exp_txn.push_back('{32'h700, 1'b0, '0});
    fork
      drive_req(1'b0, 32'h700, 1'b1, 1'b0, '0, 60, r);
      begin
        repeat (3) @(posedge clk); #3;
        rst_n = 1'b0; #1;
        n_cmp++;
        if ({pmem_read, pmem_write, i_resp, d_resp} !== 4'b0000 || pmem_address !== 32'h0) begin
          n_bad++;
          $display("FAIL midreset_ctrl: got rd/wr/iresp/dresp %b addr %h, required 0000 0",
                   {pmem_read, pmem_write, i_resp, d_resp}, pmem_address);
        end
        n_cmp++;
        if (i_rdata !== '0 || d_rdata !== '0 || pmem_wdata !== '0) begin
          n_bad++; $display("FAIL midreset_lines: got i_rdata %h, required zeros", i_rdata);
        end
        repeat (2) @(posedge clk); #2;
        mem_lat = 2;
        exp_i.push_back('{1'b1, mem_val(32'h700)});
        rst_n = 1'b1;
      end
    join
  endtask

  task automatic test_rw_both();
    int r;
    line_t wd;
    wd = {8{32'hBEEF_0800}};
    @(posedge clk); #1;
    exp_txn.push_back('{32'h800, 1'b1, wd});
    exp_d.push_back('{1'b0, '0});
    fork
      drive_req(1'b1, 32'h800, 1'b1, 1'b1, wd, 30, r);
      begin
        repeat (2) @(negedge clk);
        n_cmp++;
        if (pmem_write !== 1'b1 || pmem_read !== 1'b0) begin
          n_bad++; $display("FAIL rw_both: got rd %b wr %b, required rd 0 wr 1", pmem_read, pmem_write);
        end
      end
    join
  endtask

  task automatic test_back_to_back();
    int ri, rd;
    line_t wd;
    wd = {8{32'h0900_F00D}};
    @(posedge clk); #1;
    exp_txn.push_back('{32'h900, 1'b1, wd});
    exp_txn.push_back('{32'h900, 1'b0, '0});
    exp_i.push_back('{1'b0, '0});
    exp_d.push_back('{1'b1, wd});
    drive_req(1'b0, 32'h900, 1'b0, 1'b1, wd, 30, ri);
    drive_req(1'b1, 32'h900, 1'b1, 1'b0, '0, 30, rd);
    n_cmp++;
    if (rd != ri + 5) begin
      n_bad++; $display("FAIL b2b_latency: got d_resp cycle %0d, required %0d", rd, ri + 5);
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_idle_resp();
    test_simultaneous();
    test_streak();
    test_addr_hold();
    test_reset_mid();
    test_rw_both();
    test_back_to_back();
    repeat (4) @(negedge clk);
    n_cmp++;
    if (exp_txn.size() != 0 || exp_i.size() != 0 || exp_d.size() != 0) begin
      n_bad++;
      $display("FAIL leftover: got txn %0d i %0d d %0d outstanding, required 0 0 0",
               exp_txn.size(), exp_i.size(), exp_d.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
